// File: rtl/bus_slave_mem_pkg.sv
// Shared bus command encodings and slave FSM state type.
package bus_slave_mem_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_GUARD = 2'd3
  } state_t;

endpackage

// File: rtl/bus_slave_mem_sp_ram.sv
// Single-port word array: synchronous write, asynchronous read. Not reset.
module sp_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned N  = 31
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N:0]    wdata,
  output logic [N:0]    rdata
);

  logic [N:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_slave_mem.sv
// Bus slave responder: captures a held request, waits LATENCY cycles, acks,
// then ignores req for GUARD cycles while the upstream pipeline drains.
module bus_slave_mem #(
  parameter int unsigned N       = 31,
  parameter int unsigned AW      = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned GUARD   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [N:0] addr,
  input  logic       cmd,
  input  logic [N:0] wdata,
  output logic       ack,
  output logic [N:0] rdata,
  output logic       busy
);

  import bus_slave_mem_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q;
  logic             cmd_q;
  logic [N:0]       wdata_q;
  logic             cap_c;
  logic             we_c;
  logic             rd_c;
  logic [N:0]       mem_rdata_c;
  logic             unused_addr;

  assign unused_addr = ^addr[N:AW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_c = 1'b1;
          if (LATENCY != 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK: begin
        state_d = S_GUARD;
        cnt_d   = CNT_W'(GUARD - 1);
      end
      S_GUARD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are sampled only on capture; later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      cmd_q   <= CMD_READ;
      wdata_q <= '0;
    end else if (cap_c) begin
      addr_q  <= addr[AW-1:0];
      cmd_q   <= cmd;
      wdata_q <= wdata;
    end
  end

  assign we_c = (state_q == S_ACK) && (cmd_q == CMD_WRITE);
  assign rd_c = (state_q == S_ACK) && (cmd_q == CMD_READ);

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      ack  <= (state_d == S_ACK);
      busy <= (state_d != S_IDLE);
      if (rd_c) rdata <= mem_rdata_c;
    end
  end

  sp_ram #(
    .AW(AW),
    .N (N)
  ) u_ram (
    .clk  (clk),
    .we   (we_c),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata_c)
  );

endmodule

// File: tb/tb_bus_slave_mem.sv
// Randomized bench for bus_slave_mem: a LATENCY=2 and a LATENCY=0 instance
// share stimulus and are checked against a transaction-timeline model.
module tb_bus_slave_mem;

  localparam int unsigned GRD = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ack_v;
  logic [1:0]  busy_v;
  logic [31:0] rd_v [2];

  always #5 clk = ~clk;

  bus_slave_mem #(.N(31), .AW(4), .LATENCY(2), .GUARD(GRD)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .cmd(cmd),
    .wdata(wdata), .ack(ack_v[0]), .rdata(rd_v[0]), .busy(busy_v[0])
  );

  bus_slave_mem #(.N(31), .AW(4), .LATENCY(0), .GUARD(GRD)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .cmd(cmd),
    .wdata(wdata), .ack(ack_v[1]), .rdata(rd_v[1]), .busy(busy_v[1])
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          e = 0;
  bit          m_act  [2];
  int          m_t    [2];
  bit          m_cmd  [2];
  int          m_a    [2];
  logic [31:0] m_d    [2];
  int          m_idle [2];
  logic [31:0] m_mem  [2][16];
  bit          m_val  [2][16];
  bit          x_ack  [2];
  bit          x_busy [2];
  logic [31:0] x_rd   [2];
  bit          x_rd_ok[2];

  function automatic int lat(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_idle[i] = 0;
      x_ack[i] = 1'b0; x_busy[i] = 1'b0;
      x_rd[i] = '0; x_rd_ok[i] = 1'b1;
    end
  endtask

  // One rising edge of the model: finish due transaction, capture, derive outputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int l;
      l = lat(i);
      if (!reset_n) continue;
      if (m_act[i] && e == m_t[i] + l + 1) begin
        if (m_cmd[i]) begin
          m_mem[i][m_a[i]] = m_d[i];
          m_val[i][m_a[i]] = 1'b1;
        end else begin
          x_rd[i] = m_mem[i][m_a[i]];
          x_rd_ok[i] = m_val[i][m_a[i]];
        end
      end
      if (req && e >= m_idle[i]) begin
        m_act[i] = 1'b1; m_t[i] = e; m_cmd[i] = cmd;
        m_a[i] = int'(addr[3:0]); m_d[i] = wdata;
        m_idle[i] = e + l + int'(GRD) + 2;
      end
      x_ack[i]  = m_act[i] && (e == m_t[i] + l);
      x_busy[i] = m_act[i] && (e >= m_t[i]) && (e <= m_t[i] + l + int'(GRD));
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("ack%0d", i), {31'b0, ack_v[i]}, {31'b0, x_ack[i]});
      check_val($sformatf("busy%0d", i), {31'b0, busy_v[i]}, {31'b0, x_busy[i]});
      if (x_rd_ok[i]) check_val($sformatf("rdata%0d", i), rd_v[i], x_rd[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(logic r, logic c, logic [31:0] a, logic [31:0] d);
    req = r; cmd = c; addr = a; wdata = d;
  endtask

  // Called at a falling edge; asserts reset asynchronously, holds it n edges.
  task automatic do_reset(int n);
    reset_n = 1'b0;
    model_clear();
    #1;
    compare_all();
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) m_val[i][j] = 1'b0;
    model_clear();
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 32'h5, 32'h1111_1111);
    repeat (3) step();
    reset_n = 1'b1;

    // Write then read with an ignored upper address bit.
    drive(1'b1, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) step();
    drive(1'b1, 1'b0, 32'h8000_0005, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) step();
    check_val("rd_deadbeef0", rd_v[0], 32'hDEAD_BEEF);
    check_val("rd_deadbeef1", rd_v[1], 32'hDEAD_BEEF);

    // Request held high for ten edges.
    acks = 0;
    drive(1'b1, 1'b0, 32'h5, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      acks += int'(ack_v[0]);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_val("held_req_acks", 32'(acks), 32'd2);
    repeat (8) step();

    // Reset during WAIT of a write must leave memory untouched.
    drive(1'b1, 1'b1, 32'h3, 32'h1234_5678);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) step();
    drive(1'b1, 1'b1, 32'h3, 32'hAAAA_AAAA);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    do_reset(2);
    drive(1'b1, 1'b0, 32'h3, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) step();
    check_val("rd_after_rst0", rd_v[0], 32'h1234_5678);
    check_val("rd_after_rst1", rd_v[1], 32'h1234_5678);

    // Inputs changing mid-transaction are ignored.
    drive(1'b1, 1'b1, 32'h7, 32'hCAFE_F00D);
    step();
    drive(1'b0, 1'b1, 32'h8, 32'h0BAD_0BAD);
    repeat (8) step();
    drive(1'b1, 1'b0, 32'h7, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) step();
    check_val("rd_captured0", rd_v[0], 32'hCAFE_F00D);

    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              32'($urandom), 32'($urandom));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
